// File: rtl/bus_fetch_sequencer.sv
// Multi-cycle fetch/execute sequencer for the bus-interface CPU.
// Owns the PC, the instruction register and the Avalon-style master port.
// Each instruction walks FETCH -> EXEC1 -> EXEC2, with MIPS branch-delay-slot
// PC update, and the sequencer parks in HALTED once the PC reaches HALT_ADDR.
//
// Bus handshake: a transfer is presented by holding read or write high with
// a stable address and byteenable.
//   - While waitrequest is high, the transfer stays pending and every bus
//     output is held.
//   - A transfer completes on the first rising edge where the strobe is high
//     and waitrequest is low. Read data is sampled on that same edge.
//   - read and write are never high together.
//   - Both strobes are forced low in any cycle where reset is high.
module bus_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_byteenable,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [2:0]  state,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rt,
  output logic [31:0] pc,
  output logic [31:0] mem_data,
  output logic        active
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_EXEC1  = 3'd1;
  localparam logic [2:0] S_EXEC2  = 3'd2;
  localparam logic [2:0] S_HALTED = 3'd3;

  logic [2:0]  state_q;
  logic [2:0]  state_n;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] mem_data_q;
  logic        jt_q;
  logic [31:0] tgt_q;
  logic        pending_q;
  logic [31:0] pend_tgt_q;
  logic        active_q;

  // Decoded data-access intent during EXEC1; a store wins over a load.
  logic        data_wr;
  logic        data_rd;
  logic        data_access;
  logic [31:0] pc_upd;
  logic        pc_upd_halts;

  assign data_wr      = (state_q == S_EXEC1) && mem_write;
  assign data_rd      = (state_q == S_EXEC1) && mem_read && !mem_write;
  assign data_access  = data_wr || data_rd;

  // PC after the EXEC2 update: a pending delay-slot target takes priority.
  assign pc_upd       = pending_q ? pend_tgt_q : (pc_q + 32'd4);
  assign pc_upd_halts = (pc_upd == HALT_ADDR);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic; unused encodings 4..7 fall into HALTED.
  always_comb begin
    state_n = S_HALTED;
    case (state_q)
      S_FETCH: begin
        state_n = waitrequest ? S_FETCH : S_EXEC1;
      end
      S_EXEC1: begin
        if (data_access && waitrequest) begin
          state_n = S_EXEC1;
        end else begin
          state_n = S_EXEC2;
        end
      end
      S_EXEC2: begin
        state_n = pc_upd_halts ? S_HALTED : S_FETCH;
      end
      default: begin
        state_n = S_HALTED;
      end
    endcase
  end

  // Bus outputs decoded from the current state and the control inputs.
  always_comb begin
    read       = 1'b0;
    write      = 1'b0;
    address    = pc_q;
    byteenable = 4'h0;
    case (state_q)
      S_FETCH: begin
        read       = 1'b1;
        address    = pc_q;
        byteenable = 4'hF;
      end
      S_EXEC1: begin
        if (data_wr) begin
          write      = 1'b1;
          address    = data_addr;
          byteenable = data_byteenable;
        end else if (data_rd) begin
          read       = 1'b1;
          address    = data_addr;
          byteenable = data_byteenable;
        end
      end
      S_EXEC2: begin
        address = pc_q;
      end
      default: begin
        address = 32'h0;
      end
    endcase
    if (reset) begin
      read  = 1'b0;
      write = 1'b0;
    end
  end

  // Instruction register, data latch, jump capture and PC sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      instr_q    <= 32'h0;
      mem_data_q <= 32'h0;
      jt_q       <= 1'b0;
      tgt_q      <= 32'h0;
      pending_q  <= 1'b0;
      pend_tgt_q <= 32'h0;
      active_q   <= 1'b1;
    end else begin
      case (state_q)
        S_FETCH: begin
          // The bus is little-endian; swap the byte lanes to get the big-endian word.
          if (!waitrequest) begin
            instr_q <= {readdata[7:0], readdata[15:8],
                        readdata[23:16], readdata[31:24]};
          end
        end
        S_EXEC1: begin
          jt_q  <= jump_taken;
          tgt_q <= jump_target;
          if (data_rd && !waitrequest) begin
            mem_data_q <= readdata;
          end
        end
        S_EXEC2: begin
          pc_q <= pc_upd;
          // A jump found here redirects the instruction after the delay slot.
          // The pending flag is re-armed after it has been consumed above, so a
          // jump sitting in a delay slot chains correctly.
          pending_q <= jt_q;
          if (jt_q) begin
            pend_tgt_q <= tgt_q;
          end
          if (pc_upd_halts) begin
            active_q <= 1'b0;
          end
        end
        default: begin
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign state    = state_q;
  assign instr    = instr_q;
  assign opcode   = instr_q[31:26];
  assign funct    = instr_q[5:0];
  assign rt       = instr_q[20:16];
  assign pc       = pc_q;
  assign mem_data = mem_data_q;
  assign active   = active_q;

endmodule

// File: tb/tb_bus_fetch_sequencer.sv
// Directed testbench for bus_fetch_sequencer.
module tb_bus_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_addr;
  logic [3:0]  data_byteenable;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [2:0]  state;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [31:0] pc;
  logic [31:0] mem_data;
  logic        active;

  int checks;
  int failures;

  bus_fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .waitrequest     (waitrequest),
    .readdata        (readdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .data_addr       (data_addr),
    .data_byteenable (data_byteenable),
    .jump_taken      (jump_taken),
    .jump_target     (jump_target),
    .address         (address),
    .read            (read),
    .write           (write),
    .byteenable      (byteenable),
    .state           (state),
    .instr           (instr),
    .opcode          (opcode),
    .funct           (funct),
    .rt              (rt),
    .pc              (pc),
    .mem_data        (mem_data),
    .active          (active)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    waitrequest     = 1'b0;
    readdata        = 32'h0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    data_addr       = 32'h0;
    data_byteenable = 4'h0;
    jump_taken      = 1'b0;
    jump_target     = 32'h0;

    // 1: reset for two cycles, then release
    step();
    check("rst_read0", {31'b0, read}, 32'd0);
    check("rst_write0", {31'b0, write}, 32'd0);
    step();
    check("rst_state", {29'b0, state}, 32'd0);
    check("rst_pc", pc, 32'hBFC00000);
    check("rst_instr", instr, 32'h0);
    check("rst_mem_data", mem_data, 32'h0);
    check("rst_active", {31'b0, active}, 32'd1);
    check("rst_read_held", {31'b0, read}, 32'd0);
    reset = 1'b0;
    #1;
    check("rel_address", address, 32'hBFC00000);
    check("rel_read", {31'b0, read}, 32'd1);
    check("rel_be", {28'b0, byteenable}, 32'hF);
    check("rel_state", {29'b0, state}, 32'd0);

    // 2: fetch stalled three cycles, then byte-swapped instruction
    waitrequest = 1'b1;
    readdata    = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_state", {29'b0, state}, 32'd0);
      check("stall_address", address, 32'hBFC00000);
      check("stall_read", {31'b0, read}, 32'd1);
      check("stall_instr", instr, 32'h0);
    end
    waitrequest = 1'b0;
    readdata    = 32'h00000824;
    step();
    check("f1_instr", instr, 32'h24080000);
    check("f1_opcode", {26'b0, opcode}, 32'h09);
    check("f1_rt", {27'b0, rt}, 32'd8);
    check("f1_funct", {26'b0, funct}, 32'd0);
    check("f1_state", {29'b0, state}, 32'd1);
    check("f1_exec1_read", {31'b0, read}, 32'd0);

    // 3: taken jump; delay slot fetched first, then target
    jump_taken  = 1'b1;
    jump_target = 32'hBFC00100;
    step();
    check("j_state_exec2", {29'b0, state}, 32'd2);
    check("j_exec2_read", {31'b0, read}, 32'd0);
    check("j_exec2_write", {31'b0, write}, 32'd0);
    jump_taken  = 1'b0;
    jump_target = 32'h0;
    step();
    check("slot_state", {29'b0, state}, 32'd0);
    check("slot_pc", pc, 32'hBFC00004);
    check("slot_address", address, 32'hBFC00004);
    readdata = 32'h0;
    step();
    check("slot_exec1", {29'b0, state}, 32'd1);
    check("slot_instr", instr, 32'h0);
    step();
    check("slot_exec2", {29'b0, state}, 32'd2);
    step();
    check("tgt_pc", pc, 32'hBFC00100);
    check("tgt_address", address, 32'hBFC00100);
    check("tgt_state", {29'b0, state}, 32'd0);

    // 4: load with two wait cycles
    readdata = 32'h00100F8C;
    step();
    check("lw_instr", instr, 32'h8C0F1000);
    check("lw_opcode", {26'b0, opcode}, 32'h23);
    check("lw_rt", {27'b0, rt}, 32'd15);
    mem_read        = 1'b1;
    data_addr       = 32'h00001000;
    data_byteenable = 4'hF;
    waitrequest     = 1'b1;
    #1;
    check("lw_read", {31'b0, read}, 32'd1);
    check("lw_write", {31'b0, write}, 32'd0);
    check("lw_addr", address, 32'h00001000);
    check("lw_be", {28'b0, byteenable}, 32'hF);
    for (int i = 0; i < 2; i++) begin
      step();
      check("lw_hold_state", {29'b0, state}, 32'd1);
      check("lw_hold_read", {31'b0, read}, 32'd1);
      check("lw_hold_addr", address, 32'h00001000);
    end
    waitrequest = 1'b0;
    readdata    = 32'hDEADBEEF;
    step();
    check("lw_state_exec2", {29'b0, state}, 32'd2);
    check("lw_mem_data", mem_data, 32'hDEADBEEF);
    check("lw_exec2_read", {31'b0, read}, 32'd0);
    mem_read = 1'b0;
    step();
    check("lw_next_pc", pc, 32'hBFC00104);

    // Store and load requested together: the store wins
    readdata = 32'h000000AC;
    step();
    check("sw_state", {29'b0, state}, 32'd1);
    mem_read        = 1'b1;
    mem_write       = 1'b1;
    data_addr       = 32'h00002004;
    data_byteenable = 4'h3;
    #1;
    check("sw_write", {31'b0, write}, 32'd1);
    check("sw_read", {31'b0, read}, 32'd0);
    check("sw_addr", address, 32'h00002004);
    check("sw_be", {28'b0, byteenable}, 32'h3);
    step();
    check("sw_one_cycle", {29'b0, state}, 32'd2);
    check("sw_mem_data_kept", mem_data, 32'hDEADBEEF);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    step();
    check("sw_next_pc", pc, 32'hBFC00108);

    // 5: jump to the halt address, delay slot, then halt
    readdata = 32'h08000003;
    step();
    check("jr_state", {29'b0, state}, 32'd1);
    jump_taken  = 1'b1;
    jump_target = 32'h0;
    step();
    check("jr_exec2", {29'b0, state}, 32'd2);
    jump_taken = 1'b0;
    step();
    check("jr_slot_pc", pc, 32'hBFC0010C);
    check("jr_slot_active", {31'b0, active}, 32'd1);
    readdata = 32'h0;
    step();
    step();
    check("jr_slot_exec2", {29'b0, state}, 32'd2);
    step();
    check("halt_state", {29'b0, state}, 32'd3);
    check("halt_pc", pc, 32'h0);
    check("halt_active", {31'b0, active}, 32'd0);
    check("halt_read", {31'b0, read}, 32'd0);
    check("halt_write", {31'b0, write}, 32'd0);
    check("halt_address", address, 32'h0);
    mem_read  = 1'b1;
    mem_write = 1'b1;
    #1;
    check("halt_no_write", {31'b0, write}, 32'd0);
    check("halt_no_read", {31'b0, read}, 32'd0);
    step();
    check("halt_stays", {29'b0, state}, 32'd3);
    mem_read  = 1'b0;
    mem_write = 1'b0;

    // 6: reset during a stalled store with a jump pending
    reset = 1'b1;
    step();
    check("r2_state", {29'b0, state}, 32'd0);
    check("r2_active", {31'b0, active}, 32'd1);
    reset = 1'b0;
    step();
    check("r2_exec1", {29'b0, state}, 32'd1);
    jump_taken  = 1'b1;
    jump_target = 32'h12345678;
    step();
    jump_taken  = 1'b0;
    jump_target = 32'h0;
    step();
    check("r2_slot_pc", pc, 32'hBFC00004);
    step();
    check("r2_slot_exec1", {29'b0, state}, 32'd1);
    mem_write       = 1'b1;
    waitrequest     = 1'b1;
    data_addr       = 32'h00002000;
    data_byteenable = 4'hC;
    #1;
    check("r2_write", {31'b0, write}, 32'd1);
    check("r2_write_addr", address, 32'h00002000);
    step();
    check("r2_write_held", {31'b0, write}, 32'd1);
    reset = 1'b1;
    #1;
    check("r2_write_drop", {31'b0, write}, 32'd0);
    check("r2_read_drop", {31'b0, read}, 32'd0);
    step();
    check("r2_rst_state", {29'b0, state}, 32'd0);
    check("r2_rst_pc", pc, 32'hBFC00000);
    reset       = 1'b0;
    mem_write   = 1'b0;
    waitrequest = 1'b0;
    #1;
    check("r2_fetch_read", {31'b0, read}, 32'd1);
    check("r2_fetch_addr", address, 32'hBFC00000);
    step();
    step();
    step();
    check("r2_no_pending_pc", pc, 32'hBFC00004);
    step();
    step();
    step();
    check("r2_seq_pc", pc, 32'hBFC00008);
    check("r2_seq_state", {29'b0, state}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
